// File: rtl/ioram_arb.sv
// ioram_arb: single-port access arbiter and sequencer for the 4096x8 IO RAM.
// Three users share the RAM port:
//   - a receive byte-write path with a one-entry holding register
//   - the encoder character-read port
//   - the transmit output-read port
// Before each frame it can also sweep the whole RAM to zero.
//
// Optional feature macro: IORAM_ARB_RR_EN
//   defined   -> enc/tx contention is round-robin
//   undefined -> fixed priority, enc over tx
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   rx_wr/rx_addr/rx_data  receive write pulse, address and data
//   enc_req/enc_addr       encoder read request (level) and address
//   enc_gnt/enc_vld/enc_data
//                          read issued, data valid (next cycle), read data
//   tx_*                   transmit read port, same meaning as enc_*
//   clr_start/clr_done     start clear sweep / one-cycle done pulse
//   rx_ovf                 sticky flag: a receive byte was dropped
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata
//                          RAM port; read data has 1-cycle latency
module ioram_arb #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_wr,
  input  logic [AW-1:0] rx_addr,
  input  logic [DW-1:0] rx_data,
  input  logic          enc_req,
  input  logic [AW-1:0] enc_addr,
  output logic          enc_gnt,
  output logic          enc_vld,
  output logic [DW-1:0] enc_data,
  input  logic          tx_req,
  input  logic [AW-1:0] tx_addr,
  output logic          tx_gnt,
  output logic          tx_vld,
  output logic [DW-1:0] tx_data,
  input  logic          clr_start,
  output logic          clr_done,
  output logic          rx_ovf,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic {S_RUN, S_CLR} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic          r_pend;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pdata;
  logic          r_ovf;
  logic          r_enc_vld;
  logic          r_tx_vld;
  logic          r_clr_done;

  logic          w_drain;
  logic          w_drop;
  logic          w_load;
  logic          w_rd_ok;
  logic          w_enc_gnt;
  logic          w_tx_gnt;
  logic          w_clr_last;

`ifdef IORAM_ARB_RR_EN
  // 0 favours enc, 1 favours tx
  logic          r_rr_tx;
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_clr_last  = 1'b0;
    case (r_state)
      S_RUN: if (clr_start) w_state_nxt = S_CLR;
      S_CLR: begin
        w_clr_last = (r_cnt == {AW{1'b1}});
        if (w_clr_last) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Holding register drains only in RUN; a second byte is dropped only when
  // the entry is occupied and not leaving this cycle.
  assign w_drain = (r_state == S_RUN) && r_pend;
  assign w_drop  = rx_wr && r_pend && !w_drain;
  assign w_load  = rx_wr && !w_drop;

  // Reads only in RUN with no pending write; forced off during reset
  assign w_rd_ok = rst_n && (r_state == S_RUN) && !r_pend;

`ifdef IORAM_ARB_RR_EN
  assign w_enc_gnt = w_rd_ok && enc_req && (!tx_req || !r_rr_tx);
  assign w_tx_gnt  = w_rd_ok && tx_req && (!enc_req || r_rr_tx);
`else
  assign w_enc_gnt = w_rd_ok && enc_req;
  assign w_tx_gnt  = w_rd_ok && tx_req && !enc_req;
`endif

  // RAM port multiplexing
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = tx_addr;
    ram_wdata = r_pdata;
    if (r_state == S_CLR) begin
      ram_en    = rst_n;
      ram_we    = rst_n;
      ram_addr  = r_cnt;
      ram_wdata = '0;
    end else if (w_drain) begin
      ram_en    = rst_n;
      ram_we    = rst_n;
      ram_addr  = r_paddr;
    end else if (w_enc_gnt) begin
      ram_en    = 1'b1;
      ram_addr  = enc_addr;
    end else if (w_tx_gnt) begin
      ram_en    = 1'b1;
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_ovf      <= 1'b0;
      r_enc_vld  <= 1'b0;
      r_tx_vld   <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      if (r_state == S_CLR) r_cnt <= r_cnt + 1'b1;
      r_clr_done <= w_clr_last;
      r_enc_vld  <= w_enc_gnt;
      r_tx_vld   <= w_tx_gnt;
      if (w_load)       r_pend <= 1'b1;
      else if (w_drain) r_pend <= 1'b0;
      if (w_drop)                                r_ovf <= 1'b1;
      else if ((r_state == S_RUN) && clr_start)  r_ovf <= 1'b0;
    end
  end

`ifdef IORAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)         r_rr_tx <= 1'b0;
    else if (w_enc_gnt) r_rr_tx <= 1'b1;
    else if (w_tx_gnt)  r_rr_tx <= 1'b0;
  end
`endif

  // Holding register payload needs no reset; r_pend qualifies it
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_paddr <= rx_addr;
      r_pdata <= rx_data;
    end
  end

  assign enc_gnt  = w_enc_gnt;
  assign tx_gnt   = w_tx_gnt;
  assign enc_vld  = r_enc_vld;
  assign tx_vld   = r_tx_vld;
  assign enc_data = ram_rdata;
  assign tx_data  = ram_rdata;
  assign clr_done = r_clr_done;
  assign rx_ovf   = r_ovf;

endmodule

// File: tb/tb_ioram_arb.sv
module tb_ioram_arb;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_wr = 1'b0;
  logic [AW-1:0] rx_addr = '0;
  logic [DW-1:0] rx_data = '0;
  logic          enc_req = 1'b0;
  logic [AW-1:0] enc_addr = '0;
  logic          enc_gnt, enc_vld;
  logic [DW-1:0] enc_data;
  logic          tx_req = 1'b0;
  logic [AW-1:0] tx_addr = '0;
  logic          tx_gnt, tx_vld;
  logic [DW-1:0] tx_data;
  logic          clr_start = 1'b0;
  logic          clr_done, rx_ovf;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;
  int errs;

  always #5 clk = ~clk;

  ioram_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_wr(rx_wr), .rx_addr(rx_addr), .rx_data(rx_data),
    .enc_req(enc_req), .enc_addr(enc_addr), .enc_gnt(enc_gnt),
    .enc_vld(enc_vld), .enc_data(enc_data),
    .tx_req(tx_req), .tx_addr(tx_addr), .tx_gnt(tx_gnt),
    .tx_vld(tx_vld), .tx_data(tx_data),
    .clr_start(clr_start), .clr_done(clr_done), .rx_ovf(rx_ovf),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural synchronous RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hFF;

    // Reset with a live request: gating must hold everything off
    enc_req = 1'b1;
    cyc(); smp();
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_gnt", {30'd0, enc_gnt, tx_gnt}, 32'd0);
    cyc(); smp();
    chk("rst_flags", {28'd0, enc_vld, tx_vld, clr_done, rx_ovf}, 32'd0);
    cyc(); rst_n = 1'b1; enc_req = 1'b0; smp();
    chk("idle_en", {31'd0, ram_en}, 32'd0);

    // Receive write: issued one cycle after the pulse
    cyc(); rx_wr = 1'b1; rx_addr = 12'h005; rx_data = 8'hA5; smp();
    chk("wr_lat0", {31'd0, ram_en}, 32'd0);
    cyc(); rx_wr = 1'b0; smp();
    chk("wr_issue", {18'd0, ram_en, ram_we, ram_addr}, {18'd0, 2'b11, 12'h005});
    chk("wr_data", {24'd0, ram_wdata}, 32'h0A5);

    // Encoder read
    cyc(); enc_req = 1'b1; enc_addr = 12'h005; smp();
    chk("enc_gnt", {18'd0, enc_gnt, ram_we, ram_addr}, {18'd0, 2'b10, 12'h005});
    cyc(); enc_req = 1'b0; smp();
    chk("enc_rd", {22'd0, enc_vld, enc_gnt, enc_data}, {22'd0, 2'b10, 8'hA5});

    // Transmit read
    cyc(); tx_req = 1'b1; tx_addr = 12'h005; smp();
    chk("tx_gnt", {30'd0, tx_gnt, enc_gnt}, 32'd2);
    cyc(); tx_req = 1'b0; smp();
    chk("tx_rd", {23'd0, tx_vld, tx_data}, {23'd0, 1'b1, 8'hA5});

    // Contention for 6 cycles
    cyc(); enc_req = 1'b1; tx_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) cyc();
      smp();
`ifdef IORAM_ARB_RR_EN
      chk($sformatf("contend%0d", i), {30'd0, enc_gnt, tx_gnt},
          (i % 2 == 0) ? 32'd2 : 32'd1);
`else
      chk($sformatf("contend%0d", i), {30'd0, enc_gnt, tx_gnt}, 32'd2);
`endif
    end
    cyc(); enc_req = 1'b0; tx_req = 1'b0;

    // Pending write delays a held read by exactly one cycle
    cyc(); rx_wr = 1'b1; rx_addr = 12'h020; rx_data = 8'h77;
    enc_req = 1'b1; enc_addr = 12'h005; smp();
    chk("wd_gnt_n", {31'd0, enc_gnt}, 32'd1);
    cyc(); rx_wr = 1'b0; smp();
    chk("wd_gnt_n1", {18'd0, enc_gnt, ram_we, ram_addr}, {18'd0, 2'b01, 12'h020});
    cyc(); smp();
    chk("wd_gnt_n2", {30'd0, enc_gnt, enc_vld}, 32'd2);
    cyc(); enc_req = 1'b0; smp();
    chk("wd_rd", {23'd0, enc_vld, enc_data}, {23'd0, 1'b1, 8'hA5});

    // Preload 0x7FF
    cyc(); rx_wr = 1'b1; rx_addr = 12'h7FF; rx_data = 8'h3C;
    cyc(); rx_wr = 1'b0; smp();
    chk("pre_wr", {19'd0, ram_we, ram_addr}, {19'd0, 1'b1, 12'h7FF});

    // Sweep 1 with tx held
    cyc(); clr_start = 1'b1; smp();
    chk("clr_n", {31'd0, ram_en}, 32'd0);
    cyc(); clr_start = 1'b0; tx_req = 1'b1; tx_addr = 12'h7FF;
    errs = 0;
    for (int k = 1; k <= (1 << AW); k++) begin
      logic [AW-1:0] ea;
      if (k != 1) cyc();
      smp();
      ea = AW'(k - 1);
      if ({ram_en, ram_we, ram_addr, ram_wdata, tx_gnt, enc_gnt, clr_done} !==
          {2'b11, ea, 8'h00, 3'b000}) errs++;
    end
    chk("sweep1_errs", errs, 32'd0);
    cyc(); smp();
    chk("sweep1_done", {18'd0, clr_done, tx_gnt, ram_addr}, {18'd0, 2'b11, 12'h7FF});
    cyc(); tx_req = 1'b0; smp();
    chk("sweep1_rd", {22'd0, tx_vld, clr_done, tx_data}, {22'd0, 2'b10, 8'h00});

    // Sweep 2 with receive bytes arriving mid-sweep
    cyc(); clr_start = 1'b1; smp();
    cyc(); clr_start = 1'b0;
    errs = 0;
    for (int k = 1; k <= (1 << AW); k++) begin
      logic [AW-1:0] ea;
      if (k != 1) cyc();
      rx_wr   = (k == 10) || (k == 12);
      rx_addr = (k == 12) ? 12'h011 : 12'h010;
      rx_data = (k == 12) ? 8'h22 : 8'h11;
      smp();
      ea = AW'(k - 1);
      if ({ram_we, ram_addr, ram_wdata} !== {1'b1, ea, 8'h00}) errs++;
    end
    chk("sweep2_errs", errs, 32'd0);
    cyc(); rx_wr = 1'b0; smp();
    chk("sweep2_done", {18'd0, clr_done, ram_we, ram_addr}, {18'd0, 2'b11, 12'h010});
    chk("sweep2_wd", {23'd0, rx_ovf, ram_wdata}, {23'd0, 1'b1, 8'h11});
    cyc(); enc_req = 1'b1; enc_addr = 12'h010; smp();
    chk("rd10_gnt", {31'd0, enc_gnt}, 32'd1);
    cyc(); enc_addr = 12'h011; smp();
    chk("rd10", {22'd0, enc_vld, enc_gnt, enc_data}, {22'd0, 2'b11, 8'h11});
    cyc(); enc_req = 1'b0; smp();
    chk("rd11", {22'd0, enc_vld, rx_ovf, enc_data}, {22'd0, 2'b11, 8'h00});

    // Sweep 3: reset at address 0x200
    cyc(); clr_start = 1'b1; smp();
    cyc(); clr_start = 1'b0; smp();
    chk("ovf_clr", {31'd0, rx_ovf}, 32'd0);
    for (int k = 2; k <= 12'h200; k++) cyc();
    cyc(); rst_n = 1'b0; smp();
    chk("mid_rst", {19'd0, ram_en, ram_addr}, {19'd0, 1'b0, 12'h200});
    cyc(); rst_n = 1'b1; smp();
    chk("post_rst", {26'd0, ram_en, ram_we, clr_done, rx_ovf, enc_vld, tx_vld}, 32'd0);
    cyc(); clr_start = 1'b1; smp();
    cyc(); clr_start = 1'b0; smp();
    chk("restart0", {19'd0, ram_we, ram_addr}, {19'd0, 1'b1, 12'h000});
    cyc(); smp();
    chk("restart1", {19'd0, ram_we, ram_addr}, {19'd0, 1'b1, 12'h001});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ioram_arb.md
# ioram_arb

Single-port access arbiter and sequencer for the 4096x8 IO RAM. It shares one RAM port between three users: the serial receive path (byte writes), the LZW encoder (character reads) and the serial transmit path (output byte reads). It also runs a full-RAM clear sweep before each new frame. It sits between `ser`/`lzw_enc` and the IO RAM, and is clocked from the divided 33 MHz system clock.

## Interface
Parameters:
- `AW`, 12, RAM address width (depth 2^AW)
- `DW`, 8, RAM data width

Ports:
- `clk`  in  1  system clock (33 MHz)
- `rst_n`  in  1  reset; synchronous, active-low
- `rx_wr`  in  1  one-cycle pulse: write `rx_data` at `rx_addr`
- `rx_addr`  in  AW  receive write address
- `rx_data`  in  DW  receive write data
- `enc_req`  in  1  encoder read request (level)
- `enc_addr`  in  AW  encoder read address
- `enc_gnt`  out  1  encoder read issued this cycle
- `enc_vld`  out  1  `enc_data` valid
- `enc_data`  out  DW  encoder read data
- `tx_req`, `tx_addr`, `tx_gnt`, `tx_vld`, `tx_data`: transmit read port; same widths and meaning as the encoder port
- `clr_start`  in  1  pulse: start clear sweep
- `clr_done`  out  1  one-cycle pulse: sweep finished
- `rx_ovf`  out  1  sticky: receive byte dropped
- `ram_en`  out  1  RAM enable
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  AW  RAM address
- `ram_wdata`  out  DW  RAM write data
- `ram_rdata`  in  DW  RAM read data; synchronous, 1-cycle latency

## Operation
- FSM states: RUN (reset state) and CLR.
- RUN -> CLR on `clr_start`. `clr_start` is ignored while in CLR.
- CLR -> RUN after the write to address 2^AW-1.
- Receive holding register: one entry (`pend`, `paddr`, `pdata`).
  - `rx_wr` loads the register.
  - If `rx_wr` arrives while `pend`=1 and the entry is not being drained this cycle, the new byte is dropped and `rx_ovf` sets.
  - Load and drain in the same cycle is legal. The new byte is kept.
- RUN arbitration, one access per cycle:
  1. `pend`: write `pdata` at `paddr`. No read grant that cycle.
  2. Otherwise `enc_req`/`tx_req` per the configured read policy.
- CLR:
  - Counter sweeps 0..2^AW-1, one write per cycle, `ram_we`=1, `ram_wdata`=0.
  - No read grants are issued.
  - The holding register is retained and drained in the first RUN cycle.
- Read handshake:
  - A requester holds `req` and `addr` stable until it sees `gnt`.
  - `gnt` is combinational in the issuing cycle. `ram_addr` = requester address in that cycle.
  - The requester may keep `req` high after `gnt` to issue the next read back-to-back.
- `*_data` = `ram_rdata`. It is meaningful only while `*_vld`=1.
- `rx_ovf` clears only on reset or `clr_start`.
- Addresses are AW bits. No wrap checking is done on requester addresses. The clear counter wraps to 0 on completion.

## Timing
- Reset (`rst_n`=0 at posedge):
  - state RUN, `pend`=0, clear counter 0, `rx_ovf`=0.
  - Round-robin pointer favours enc.
  - `enc_vld`=`tx_vld`=`clr_done`=0.
- While `rst_n`=0, `ram_en`, `ram_we`, `enc_gnt` and `tx_gnt` are forced to 0.
- Receive write latency: `rx_wr` at cycle N -> RAM write at cycle N+1, provided the block is in RUN.
- Read latency: `gnt` at cycle N -> `*_vld`=1 and data at cycle N+1.
- A receive write pending at cycle N delays a competing read grant by exactly one cycle.
- Clear sweep: `clr_start` at N -> writes at N+1..N+2^AW -> `clr_done` at N+2^AW+1, which is also the first RUN cycle.
- Reset mid-sweep: the sweep aborts immediately and the next `clr_start` restarts at address 0.

## Configuration
- `IORAM_ARB_RR_EN` defined:
  - enc/tx contention is round-robin.
  - The pointer flips to the other requester after each read grant.
- `IORAM_ARB_RR_EN` undefined:
  - Fixed priority, enc over tx.
  - tx is served only when `enc_req`=0.
- The receive write keeps top priority in both modes.

## Test plan
- Idle. `rx_wr` with addr 0x005, data 0xA5 at N -> N+1: `ram_en`=`ram_we`=1, `ram_addr`=0x005, `ram_wdata`=0xA5. Then an enc read of 0x005 -> `enc_vld`=1 with `enc_data`=0xA5 one cycle after `enc_gnt`.
- `enc_req` and `tx_req` both held for 6 cycles:
  - with `IORAM_ARB_RR_EN`: grants enc,tx,enc,tx,enc,tx.
  - without: 6 enc grants, no tx grant.
- `enc_req` held while `rx_wr` pulses at N -> no `enc_gnt` at N+1 (write issued), `enc_gnt` at N+2.
- `clr_start` after preloading 0x7FF=0x3C:
  - 4096 write cycles with `wdata`=0, `clr_done` at cycle 4097.
  - `tx_req` held throughout gets no grant until 4097.
  - A later read of 0x7FF returns 0x00.
- Two `rx_wr` pulses (0x010=0x11, 0x011=0x22) during CLR -> `rx_ovf`=1; after `clr_done`, 0x010 reads 0x11 and 0x011 reads 0x00.
- `rst_n` low for 1 cycle at sweep address 0x200 -> next cycle all outputs 0 and state RUN; the next `clr_start` sweep begins at 0x000.
